npu_queue_ctrl: RTL and testbench
=================================

Name: npu_queue_ctrl

Overview:
- Sequences all traffic between the execute stage's NPU ports and the neural processing unit (NPU).
- Buffers configuration words and input operands in two outbound queues, and results in one inbound queue.
- Enforces ordering: all configuration words are delivered before the input stream, and input is fully drained before any reconfiguration.
- Sits between the execute stage and the NPU, and drives the pipeline stall when a queue cannot accept or supply a word.

Parameters:
- CFG_DEPTH, 8, configuration queue depth in words (power of 2, >=2).
- IN_DEPTH, 16, input-data queue depth in words (power of 2, >=2).
- OUT_DEPTH, 16, output-data queue depth in words (power of 2, >=2).

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  synchronous reset, active-low.
- iNpuConfigWe  in  1  execute stage pushes a config word.
- iNpuConfigFifo  in  32  config word.
- iNpuDataWe  in  1  execute stage pushes an input operand.
- iNpuDataFifo  in  32  input operand.
- iNpuDataRe  in  1  execute stage pops a result.
- oNpuDataFifo  out  32  result at the head of the output queue.
- oStall  out  1  pipeline must hold the current execute-stage op.
- oNpuCfgValid  out  1  config word offered to the NPU.
- oNpuCfgData  out  32  config word at the head of the config queue.
- iNpuCfgReady  in  1  NPU accepts the config word.
- oNpuInValid  out  1  input operand offered to the NPU.
- oNpuInData  out  32  operand at the head of the input queue.
- iNpuInReady  in  1  NPU accepts the operand.
- iNpuOutValid  in  1  NPU offers a result.
- iNpuOutData  in  32  result word.
- oNpuOutReady  out  1  output queue can accept a result.
- iNpuBusy  in  1  NPU still computing on accepted input.
- oState  out  2  controller state, for debug.

Behaviour:
- Queue structure:
  - Each queue is first-word-fall-through: the head word is visible combinationally while the queue is non-empty.
  - Each queue keeps a count of width log2(DEPTH)+1.
  - Read and write pointers wrap modulo DEPTH.
- Transfer rules:
  - Any valid/ready pair transfers on a rising edge when both signals are high.
  - A push while full is refused, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty queue leaves the count unchanged.
- Stall:
  - oStall = iRst_n & ((iNpuConfigWe & cfgFull) | (iNpuDataWe & inFull) | (iNpuDataRe & outEmpty)).
  - While oStall=1, none of the three execute-side pushes or pops take effect; the pipeline re-presents the op.
- Execute-side result read:
  - oNpuDataFifo = output-queue head when the queue is non-empty, else 0.
  - A pop occurs on iNpuDataRe & !outEmpty & !oStall.
- oNpuOutReady = !outFull.
- State machine (oState encoding: IDLE=0, CFG=1, RUN=2, DRAIN=3):
  - IDLE: if cfg queue is non-empty -> CFG; else if input queue is non-empty -> RUN (previous configuration is reused).
  - CFG: oNpuCfgValid = !cfgEmpty. When the queue empties (count 1 and a handshake this cycle, with no push this cycle) -> RUN next cycle.
  - RUN: oNpuInValid = !inEmpty. If the cfg queue is non-empty -> DRAIN. The cfg queue is not offered to the NPU in RUN.
  - DRAIN: keeps streaming input. When inEmpty & !iNpuBusy -> CFG.
  - RUN -> IDLE when inEmpty & cfgEmpty & !iNpuBusy.
  - oNpuCfgValid is 0 outside CFG; oNpuInValid is 0 outside RUN and DRAIN.
- Reset (while iRst_n=0 at an edge):
  - All counts and pointers go to 0; state goes to IDLE.
  - oNpuCfgValid, oNpuInValid, oStall = 0; oNpuOutReady = 1 after reset; oNpuDataFifo = 0; oState = 0.
  - Pushes and pops in the reset cycle are discarded.
  - Reset mid-transfer drops all queued words.
- Latency:
  - A word pushed at edge N is visible at the NPU-side head after edge N, provided the state permits offering it.
  - A result accepted at edge N is readable by the execute stage in cycle N+1.

Decomposition:
- Shared package, npu_pkg, holds:
  - state encoding localparams: NPU_IDLE, NPU_CFG, NPU_RUN, NPU_DRAIN;
  - the 32-bit word-width constant.
- One sub-module, npu_sync_fifo (parameters WIDTH, DEPTH), instantiated three times. It provides push/pop, full/empty, count and FWFT head.
- The controller FSM and stall logic live in npu_queue_ctrl.

Test Plan:
- Config then data:
  - Stimulus: push cfg 0xC0000001 and 0xC0000002, then data 0x11 and 0x22; iNpuCfgReady = iNpuInReady = 1.
  - Required: the NPU sees 0xC0000001, 0xC0000002 in CFG, then 0x11, 0x22 in RUN; oNpuInValid stays 0 until both cfg words have transferred.
- Input full:
  - Stimulus: iNpuInReady=0 in RUN; push 16 data words, then a 17th.
  - Required: the 17th push sees oStall=1 and the count stays 16. Raising iNpuInReady for one cycle lets the retried push succeed the following cycle.
- Result read on empty:
  - Stimulus: iNpuDataRe=1 with the output queue empty.
  - Required: oStall=1. Then iNpuOutValid=1, iNpuOutData=0xDEADBEEF -> next cycle oStall=0, oNpuDataFifo=0xDEADBEEF, and the pop completes.
- Reconfiguration:
  - Stimulus: in RUN with 3 input words queued, push a cfg word; hold iNpuBusy=1 for 2 cycles after the input queue empties.
  - Required: state goes to DRAIN, all 3 words reach the NPU, and CFG is entered only after iNpuBusy falls; the cfg word is then offered.
- Wrap-around:
  - Stimulus: 40 data words streamed through the input queue with random iNpuInReady.
  - Required: the NPU receives all 40 words in order with no loss or duplication.
- Reset mid-operation:
  - Stimulus: iRst_n=0 for one edge with 5 words queued in each queue.
  - Required: all valids are 0, oState=0, oNpuDataFifo=0, counts are 0, and no stale word appears afterward.

Source files
------------

// File: rtl/npu_queue_ctrl_pkg.sv
// Shared definitions for the NPU queue controller: word width and controller state encoding.
package npu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        NPU_IDLE  = 2'd0,
        NPU_CFG   = 2'd1,
        NPU_RUN   = 2'd2,
        NPU_DRAIN = 2'd3
    } npuState_e;

endpackage

// File: rtl/npu_queue_ctrl_if.sv
// NPU-side handshake bundle: config and input streams toward the NPU, result stream back.
interface npu_queue_ctrl_if;
    import npu_pkg::*;

    logic              cfgValid;
    logic [WORD_W-1:0] cfgData;
    logic              cfgReady;
    logic              inValid;
    logic [WORD_W-1:0] inData;
    logic              inReady;
    logic              outValid;
    logic [WORD_W-1:0] outData;
    logic              outReady;
    logic              busy;

    modport master (
        output cfgValid, cfgData, inValid, inData, outReady,
        input  cfgReady, inReady, outValid, outData, busy
    );

    modport slave (
        input  cfgValid, cfgData, inValid, inData, outReady,
        output cfgReady, inReady, outValid, outData, busy
    );

endinterface

// File: rtl/npu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module npu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iPush,
    input  logic [WIDTH-1:0]         iPushData,
    input  logic                     iPop,
    output logic [WIDTH-1:0]         oHead,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             pushOk;
    logic             popOk;

    assign oFull  = (count == FULL_CNT);
    assign oEmpty = (count == '0);
    assign oCount = count;
    assign oHead  = oEmpty ? '0 : mem[rdPtr];

    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign pushOk = iPush & ~oFull;
    assign popOk  = iPop & ~oEmpty;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst_n && pushOk) mem[wrPtr] <= iPushData;
    end

endmodule

// File: rtl/npu_queue_ctrl.sv
// Queues config/input words toward the NPU and results back, sequencing reconfiguration and pipeline stalls.
module npu_queue_ctrl
    import npu_pkg::*;
#(
    parameter int CFG_DEPTH = 8,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iNpuConfigWe,
    input  logic [WORD_W-1:0] iNpuConfigFifo,
    input  logic              iNpuDataWe,
    input  logic [WORD_W-1:0] iNpuDataFifo,
    input  logic              iNpuDataRe,
    output logic [WORD_W-1:0] oNpuDataFifo,
    output logic              oStall,
    npu_queue_ctrl_if.master  npuIf,
    output logic [1:0]        oState
);

    localparam int CFG_AW = $clog2(CFG_DEPTH);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam logic [CFG_AW:0] CFG_ONE      = (CFG_AW+1)'(1);
    localparam logic [IN_AW:0]  IN_FULL_CNT  = (IN_AW+1)'(IN_DEPTH);
    localparam logic [OUT_AW:0] OUT_FULL_CNT = (OUT_AW+1)'(OUT_DEPTH);

    npuState_e state, stateNext;

    logic [WORD_W-1:0] cfgHead, inHead, outHead;
    logic              cfgFull, cfgEmpty, inFull, inEmpty, outFull, outEmpty;
    logic [CFG_AW:0]   cfgCount;
    logic [IN_AW:0]    inCount;
    logic [OUT_AW:0]   outCount;
    logic              cfgValid, inValid;
    logic              cfgPush, inPush, outPop;
    logic              cfgHs, inHs, outHs;

    assign oStall = iRst_n & ((iNpuConfigWe & cfgFull) |
                              (iNpuDataWe   & inFull)  |
                              (iNpuDataRe   & outEmpty));

    assign cfgPush = iNpuConfigWe & ~oStall;
    assign inPush  = iNpuDataWe   & ~oStall;
    assign outPop  = iNpuDataRe   & ~outEmpty & ~oStall;

    assign cfgHs = cfgValid & npuIf.cfgReady;
    assign inHs  = inValid  & npuIf.inReady;
    assign outHs = npuIf.outValid & ~outFull;

    assign npuIf.cfgValid = cfgValid;
    assign npuIf.cfgData  = cfgHead;
    assign npuIf.inValid  = inValid;
    assign npuIf.inData   = inHead;
    assign npuIf.outReady = ~outFull;
    assign oNpuDataFifo   = iRst_n ? outHead : '0;
    assign oState         = state;

    npu_sync_fifo #(.WIDTH(WORD_W), .DEPTH(CFG_DEPTH)) uCfgFifo (
        .iClk(iClk), .iRst_n(iRst_n),
        .iPush(cfgPush), .iPushData(iNpuConfigFifo), .iPop(cfgHs),
        .oHead(cfgHead), .oFull(cfgFull), .oEmpty(cfgEmpty), .oCount(cfgCount)
    );

    npu_sync_fifo #(.WIDTH(WORD_W), .DEPTH(IN_DEPTH)) uInFifo (
        .iClk(iClk), .iRst_n(iRst_n),
        .iPush(inPush), .iPushData(iNpuDataFifo), .iPop(inHs),
        .oHead(inHead), .oFull(inFull), .oEmpty(inEmpty), .oCount(inCount)
    );

    npu_sync_fifo #(.WIDTH(WORD_W), .DEPTH(OUT_DEPTH)) uOutFifo (
        .iClk(iClk), .iRst_n(iRst_n),
        .iPush(outHs), .iPushData(npuIf.outData), .iPop(outPop),
        .oHead(outHead), .oFull(outFull), .oEmpty(outEmpty), .oCount(outCount)
    );

    always_ff @(posedge iClk) begin
        if (!iRst_n) state <= NPU_IDLE;
        else         state <= stateNext;
    end

    // Valids are held low during reset so no handshake can complete in the reset cycle.
    always_comb begin
        stateNext = state;
        cfgValid  = 1'b0;
        inValid   = 1'b0;
        case (state)
            NPU_IDLE: begin
                if (!cfgEmpty)     stateNext = NPU_CFG;
                else if (!inEmpty) stateNext = NPU_RUN;
            end
            NPU_CFG: begin
                cfgValid = iRst_n & ~cfgEmpty;
                if ((cfgCount == CFG_ONE) && cfgHs && !cfgPush) stateNext = NPU_RUN;
            end
            NPU_RUN: begin
                inValid = iRst_n & ~inEmpty;
                if (!cfgEmpty)                        stateNext = NPU_DRAIN;
                else if (inEmpty && !npuIf.busy)      stateNext = NPU_IDLE;
            end
            NPU_DRAIN: begin
                inValid = iRst_n & ~inEmpty;
                if (inEmpty && !npuIf.busy) stateNext = NPU_CFG;
            end
            default: stateNext = NPU_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst_n) begin
            assert (inCount <= IN_FULL_CNT && outCount <= OUT_FULL_CNT);
        end
    end

endmodule

// File: tb/tb_npu_queue_ctrl.sv
// Randomized and directed bench for npu_queue_ctrl against a queue-based behavioural model.
module tb_npu_queue_ctrl;
    import npu_pkg::*;

    localparam int CFG_DEPTH = 8;
    localparam int IN_DEPTH  = 16;
    localparam int OUT_DEPTH = 16;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iNpuConfigWe = 1'b0;
    logic [31:0] iNpuConfigFifo = '0;
    logic        iNpuDataWe = 1'b0;
    logic [31:0] iNpuDataFifo = '0;
    logic        iNpuDataRe = 1'b0;
    logic [31:0] oNpuDataFifo;
    logic        oStall;
    logic [1:0]  oState;

    npu_queue_ctrl_if npuIf ();

    npu_queue_ctrl #(.CFG_DEPTH(CFG_DEPTH), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iNpuConfigWe(iNpuConfigWe), .iNpuConfigFifo(iNpuConfigFifo),
        .iNpuDataWe(iNpuDataWe), .iNpuDataFifo(iNpuDataFifo),
        .iNpuDataRe(iNpuDataRe), .oNpuDataFifo(oNpuDataFifo),
        .oStall(oStall), .npuIf(npuIf), .oState(oState)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Model: the three queues as plain word lists plus the controller mode (0 idle, 1 cfg, 2 run, 3 drain).
    logic [31:0] cq[$], iq[$], oq[$];
    int          mSt = 0;
    logic [31:0] cfgSeen[$], inSeen[$];
    logic        lastStall;
    logic [31:0] lastDataOut;
    logic [1:0]  lastState;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit doCheck);
        bit          eStall, eCfgV, eInV, cfgHs, inHs, outHs, cfgPushOk, inPushOk, outPop;
        logic [31:0] eDout, cfgWord, inWord, outWord;
        bit          busy, rstN;
        int          nxt;
        #2;
        rstN   = iRst_n;
        eStall = rstN && ((iNpuConfigWe && cq.size() == CFG_DEPTH) ||
                          (iNpuDataWe && iq.size() == IN_DEPTH) ||
                          (iNpuDataRe && oq.size() == 0));
        eCfgV  = rstN && mSt == 1 && cq.size() > 0;
        eInV   = rstN && (mSt == 2 || mSt == 3) && iq.size() > 0;
        eDout  = (rstN && oq.size() > 0) ? oq[0] : 32'h0;
        if (doCheck) begin
            checkVal("stall", 32'(oStall), 32'(eStall));
            checkVal("cfgValid", 32'(npuIf.cfgValid), 32'(eCfgV));
            checkVal("inValid", 32'(npuIf.inValid), 32'(eInV));
            checkVal("outReady", 32'(npuIf.outReady), 32'(oq.size() < OUT_DEPTH));
            checkVal("dataOut", oNpuDataFifo, eDout);
            checkVal("state", 32'(oState), 32'(mSt));
            if (eCfgV) checkVal("cfgData", npuIf.cfgData, cq[0]);
            if (eInV)  checkVal("inData", npuIf.inData, iq[0]);
        end
        lastStall   = oStall;
        lastDataOut = oNpuDataFifo;
        lastState   = oState;
        if (npuIf.cfgValid && npuIf.cfgReady) cfgSeen.push_back(npuIf.cfgData);
        if (npuIf.inValid && npuIf.inReady)   inSeen.push_back(npuIf.inData);
        cfgHs     = eCfgV && npuIf.cfgReady;
        inHs      = eInV && npuIf.inReady;
        outHs     = npuIf.outValid && oq.size() < OUT_DEPTH;
        cfgPushOk = iNpuConfigWe && !eStall && cq.size() < CFG_DEPTH;
        inPushOk  = iNpuDataWe && !eStall && iq.size() < IN_DEPTH;
        outPop    = iNpuDataRe && !eStall && oq.size() > 0;
        cfgWord   = iNpuConfigFifo;
        inWord    = iNpuDataFifo;
        outWord   = npuIf.outData;
        busy      = npuIf.busy;
        @(posedge iClk);
        if (!rstN) begin
            cq.delete(); iq.delete(); oq.delete(); mSt = 0;
        end else begin
            nxt = mSt;
            case (mSt)
                0: if (cq.size() > 0) nxt = 1; else if (iq.size() > 0) nxt = 2;
                1: if (cq.size() == 1 && cfgHs && !cfgPushOk) nxt = 2;
                2: if (cq.size() > 0) nxt = 3; else if (iq.size() == 0 && !busy) nxt = 0;
                default: if (iq.size() == 0 && !busy) nxt = 1;
            endcase
            mSt = nxt;
            if (cfgHs)     void'(cq.pop_front());
            if (inHs)      void'(iq.pop_front());
            if (outPop)    void'(oq.pop_front());
            if (cfgPushOk) cq.push_back(cfgWord);
            if (inPushOk)  iq.push_back(inWord);
            if (outHs)     oq.push_back(outWord);
        end
        @(negedge iClk);
    endtask

    task automatic idleInputs();
        iNpuConfigWe = 1'b0; iNpuDataWe = 1'b0; iNpuDataRe = 1'b0;
        npuIf.outValid = 1'b0; npuIf.outData = '0; npuIf.busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] sent[40];
        int          idx;
        int          budget;

        npuIf.cfgReady = 1'b0; npuIf.inReady = 1'b0;
        idleInputs();
        @(negedge iClk);
        step(0);
        step(0);
        iRst_n = 1'b1;
        #1;
        checkVal("rstState", 32'(oState), 32'(NPU_IDLE));
        checkVal("rstOutReady", 32'(npuIf.outReady), 32'd1);
        checkVal("rstDataOut", oNpuDataFifo, 32'h0);

        // Config words precede the input stream.
        npuIf.cfgReady = 1'b1; npuIf.inReady = 1'b1;
        cfgSeen.delete(); inSeen.delete();
        iNpuConfigWe = 1'b1; iNpuConfigFifo = 32'hC0000001; step(1);
        iNpuConfigFifo = 32'hC0000002; step(1);
        iNpuConfigWe = 1'b0;
        iNpuDataWe = 1'b1; iNpuDataFifo = 32'h11; step(1);
        iNpuDataFifo = 32'h22; step(1);
        iNpuDataWe = 1'b0;
        repeat (6) step(1);
        checkVal("cfgSeenN", cfgSeen.size(), 32'd2);
        checkVal("inSeenN", inSeen.size(), 32'd2);
        if (cfgSeen.size() == 2) begin
            checkVal("cfgSeen0", cfgSeen[0], 32'hC0000001);
            checkVal("cfgSeen1", cfgSeen[1], 32'hC0000002);
        end
        if (inSeen.size() == 2) begin
            checkVal("inSeen0", inSeen[0], 32'h11);
            checkVal("inSeen1", inSeen[1], 32'h22);
        end

        // Input queue full: the 17th push stalls until a slot frees.
        npuIf.inReady = 1'b0; inSeen.delete();
        iNpuDataWe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iNpuDataFifo = 32'h100 + 32'(i); step(1);
        end
        iNpuDataFifo = 32'h200; step(1);
        checkVal("inFullStall", 32'(lastStall), 32'd1);
        npuIf.inReady = 1'b1; step(1);
        checkVal("inFullPopStall", 32'(lastStall), 32'd1);
        npuIf.inReady = 1'b0; step(1);
        checkVal("retryPush", 32'(lastStall), 32'd0);
        iNpuDataWe = 1'b0; npuIf.inReady = 1'b1;
        repeat (20) step(1);
        checkVal("fullSeenN", inSeen.size(), 32'd17);
        if (inSeen.size() == 17) begin
            checkVal("fullSeenFirst", inSeen[0], 32'h100);
            checkVal("fullSeenLast", inSeen[16], 32'h200);
        end

        // Result read from an empty output queue.
        iNpuDataRe = 1'b1; npuIf.outValid = 1'b1; npuIf.outData = 32'hDEADBEEF;
        step(1);
        checkVal("readEmptyStall", 32'(lastStall), 32'd1);
        npuIf.outValid = 1'b0;
        step(1);
        checkVal("readStall", 32'(lastStall), 32'd0);
        checkVal("readData", lastDataOut, 32'hDEADBEEF);
        iNpuDataRe = 1'b0;
        step(1);
        checkVal("readDrained", lastDataOut, 32'h0);

        // Reconfiguration while input is queued.
        npuIf.cfgReady = 1'b0; npuIf.inReady = 1'b0; inSeen.delete(); cfgSeen.delete();
        iNpuDataWe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iNpuDataFifo = 32'h31 + 32'(i); step(1);
        end
        iNpuDataWe = 1'b0;
        iNpuConfigWe = 1'b1; iNpuConfigFifo = 32'hC0FFEE00; step(1);
        iNpuConfigWe = 1'b0;
        npuIf.inReady = 1'b1; npuIf.busy = 1'b1;
        budget = 0;
        while (iq.size() > 0 && budget < 20) begin
            step(1); budget++;
        end
        checkVal("drainTimeout", 32'(iq.size()), 32'd0);
        step(1); step(1);
        checkVal("drainHold", 32'(lastState), 32'(NPU_DRAIN));
        npuIf.busy = 1'b0;
        step(1);
        #1;
        checkVal("reCfgState", 32'(oState), 32'(NPU_CFG));
        checkVal("reCfgValid", 32'(npuIf.cfgValid), 32'd1);
        checkVal("reCfgData", npuIf.cfgData, 32'hC0FFEE00);
        checkVal("drainSeenN", inSeen.size(), 32'd3);
        if (inSeen.size() == 3) begin
            checkVal("drainSeen0", inSeen[0], 32'h31);
            checkVal("drainSeen2", inSeen[2], 32'h33);
        end
        npuIf.cfgReady = 1'b1;
        repeat (4) step(1);

        // Wrap-around: 40 words through the input queue with random ready.
        for (int i = 0; i < 40; i++) sent[i] = $urandom;
        inSeen.delete(); idx = 0; budget = 0;
        while ((idx < 40 || inSeen.size() < 40) && budget < 1000) begin
            iNpuDataWe = (idx < 40);
            iNpuDataFifo = (idx < 40) ? sent[idx] : 32'h0;
            npuIf.inReady = 1'($urandom_range(0, 1));
            step(1);
            if (iNpuDataWe && !lastStall) idx++;
            budget++;
        end
        iNpuDataWe = 1'b0;
        checkVal("wrapSeenN", inSeen.size(), 32'd40);
        for (int i = 0; i < 40; i++) begin
            if (i < inSeen.size()) checkVal("wrapOrder", inSeen[i], sent[i]);
        end
        npuIf.inReady = 1'b1;
        repeat (4) step(1);

        // Reset with words queued everywhere.
        npuIf.cfgReady = 1'b0; npuIf.inReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iNpuConfigWe = 1'b1; iNpuConfigFifo = 32'hCF00 + 32'(i);
            iNpuDataWe = 1'b1;   iNpuDataFifo = 32'hDA00 + 32'(i);
            npuIf.outValid = 1'b1; npuIf.outData = 32'h0E00 + 32'(i);
            step(1);
        end
        idleInputs();
        iRst_n = 1'b0;
        step(1);
        iRst_n = 1'b1;
        #1;
        checkVal("midRstState", 32'(oState), 32'(NPU_IDLE));
        checkVal("midRstCfgV", 32'(npuIf.cfgValid), 32'd0);
        checkVal("midRstInV", 32'(npuIf.inValid), 32'd0);
        checkVal("midRstData", oNpuDataFifo, 32'h0);
        checkVal("midRstOutRdy", 32'(npuIf.outReady), 32'd1);
        npuIf.cfgReady = 1'b1; npuIf.inReady = 1'b1;
        cfgSeen.delete(); inSeen.delete();
        repeat (6) step(1);
        checkVal("noStaleCfg", cfgSeen.size(), 32'd0);
        checkVal("noStaleIn", inSeen.size(), 32'd0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            iRst_n         = ($urandom_range(0, 149) != 0);
            iNpuConfigWe   = ($urandom_range(0, 9) < 2);
            iNpuConfigFifo = $urandom;
            iNpuDataWe     = ($urandom_range(0, 9) < 5);
            iNpuDataFifo   = $urandom;
            iNpuDataRe     = ($urandom_range(0, 9) < 4);
            npuIf.cfgReady = 1'($urandom_range(0, 1));
            npuIf.inReady  = 1'($urandom_range(0, 1));
            npuIf.outValid = ($urandom_range(0, 9) < 5);
            npuIf.outData  = $urandom;
            npuIf.busy     = ($urandom_range(0, 9) < 2);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
